// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: holds one EX instruction, runs its load/store over a valid/ready
// data-memory port, aligns load/store data, and forwards results and HI/LO back to ID.
module mem_stage_hs #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [31:0]           ex_pc,
    input  logic                  ex_mem_en,
    input  logic                  ex_mem_we,
    input  logic [2:0]            ex_mem_op,
    input  logic                  ex_rf_we,
    input  logic [REG_AW-1:0]     ex_rf_waddr,
    input  logic [DATA_W-1:0]     ex_result,
    input  logic [DATA_W-1:0]     ex_sdata,
    input  logic [2*DATA_W+1:0]   ex_hilo,
    output logic                  dreq_valid,
    input  logic                  dreq_ready,
    output logic                  dreq_we,
    output logic [ADDR_W-1:0]     dreq_addr,
    output logic [DATA_W/8-1:0]   dreq_wstrb,
    output logic [DATA_W-1:0]     dreq_wdata,
    input  logic                  dresp_valid,
    input  logic [DATA_W-1:0]     dresp_rdata,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [31:0]           wb_pc,
    output logic                  wb_rf_we,
    output logic [REG_AW-1:0]     wb_rf_waddr,
    output logic [DATA_W-1:0]     wb_rf_wdata,
    output logic [2*DATA_W+1:0]   wb_hilo,
    output logic                  wb_exc_ale,
    output logic                  fwd_rf_we,
    output logic [REG_AW-1:0]     fwd_waddr,
    output logic [DATA_W-1:0]     fwd_wdata,
    output logic [2*DATA_W+1:0]   fwd_hilo,
    output logic                  fwd_ld_busy
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int HW    = 2 * DATA_W + 2;
    localparam bit IS64  = (DATA_W == 64);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         pc_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [2:0]          op_q;
    logic                rf_we_q;
    logic [REG_AW-1:0]   waddr_q;
    logic [DATA_W-1:0]   result_q;
    logic [DATA_W-1:0]   sdata_q;
    logic [HW-1:0]       hilo_q;
    logic                ale_q;

    logic                capture;
    logic                ex_ale;
    logic                load_latch;
    state_e              cap_state;
    logic [OFF_W-1:0]    off;
    logic [DATA_W-1:0]   rd_shift;
    logic [DATA_W-1:0]   ld_data;
    logic [NB-1:0]       strb_base;
    logic [DATA_W-1:0]   st_data;
    logic [ADDR_W-1:0]   addr_al;
    logic                req_on;

    assign ex_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && wb_ready);
    assign capture  = ex_valid && ex_ready && !flush;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        ex_ale = 1'b0;
        case (ex_mem_op)
            3'd0, 3'd1: ex_ale = 1'b0;
            3'd2, 3'd3: ex_ale = ex_result[0];
            3'd4:       ex_ale = |ex_result[1:0];
            3'd5:       ex_ale = !IS64 || (|ex_result[1:0]);
            3'd6:       ex_ale = !IS64 || (|ex_result[2:0]);
            default:    ex_ale = 1'b1;
        endcase
        ex_ale    = ex_ale && ex_mem_en;
        cap_state = (ex_mem_en && !ex_ale) ? S_REQ : S_DONE;
    end

    always_comb begin
        state_d    = state_q;
        load_latch = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (capture) state_d = cap_state;
            end
            S_REQ: begin
                // A response arriving with the acceptance closes the transaction in one step.
                if (dreq_ready) begin
                    if (flush) begin
                        state_d = dresp_valid ? S_IDLE : S_DRAIN;
                    end else if (dresp_valid) begin
                        state_d    = S_DONE;
                        load_latch = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = dresp_valid ? S_IDLE : S_DRAIN;
                end else if (dresp_valid) begin
                    state_d    = S_DONE;
                    load_latch = 1'b1;
                end
            end
            S_DONE: begin
                if (flush)         state_d = S_IDLE;
                else if (wb_ready) state_d = capture ? cap_state : S_IDLE;
            end
            S_DRAIN: begin
                if (dresp_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign off      = result_q[OFF_W-1:0];
    assign rd_shift = dresp_rdata >> {off, 3'b000};

    always_comb begin
        ld_data = rd_shift;
        case (op_q)
            3'd0:    ld_data = DATA_W'($signed(rd_shift[7:0]));
            3'd1:    ld_data = DATA_W'(rd_shift[7:0]);
            3'd2:    ld_data = DATA_W'($signed(rd_shift[15:0]));
            3'd3:    ld_data = DATA_W'(rd_shift[15:0]);
            3'd4:    ld_data = DATA_W'($signed(rd_shift[31:0]));
            3'd5:    ld_data = DATA_W'(rd_shift[31:0]);
            default: ld_data = rd_shift;
        endcase
    end

    always_comb begin
        strb_base = '1;
        st_data   = sdata_q;
        case (op_q)
            3'd0, 3'd1: begin
                strb_base = NB'(1);
                st_data   = {NB{sdata_q[7:0]}};
            end
            3'd2, 3'd3: begin
                strb_base = NB'(3);
                st_data   = {(NB/2){sdata_q[15:0]}};
            end
            3'd4, 3'd5: begin
                strb_base = NB'(15);
                st_data   = {(NB/4){sdata_q[31:0]}};
            end
            default: begin
                strb_base = '1;
                st_data   = sdata_q;
            end
        endcase
    end

    always_comb begin
        addr_al              = ADDR_W'(result_q);
        addr_al[OFF_W-1:0]   = '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            op_q     <= '0;
            rf_we_q  <= 1'b0;
            waddr_q  <= '0;
            result_q <= '0;
            sdata_q  <= '0;
            hilo_q   <= '0;
            ale_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                pc_q     <= ex_pc;
                mem_en_q <= ex_mem_en;
                mem_we_q <= ex_mem_we;
                op_q     <= ex_mem_op;
                rf_we_q  <= ex_rf_we;
                waddr_q  <= ex_rf_waddr;
                result_q <= ex_result;
                sdata_q  <= ex_sdata;
                hilo_q   <= ex_hilo;
                ale_q    <= ex_ale;
            end else if (load_latch && !mem_we_q) begin
                result_q <= ld_data;
            end
        end
    end

    assign req_on     = (state_q == S_REQ);
    assign dreq_valid = req_on;
    assign dreq_we    = req_on && mem_we_q;
    assign dreq_addr  = req_on ? addr_al : '0;
    assign dreq_wstrb = (req_on && mem_we_q) ? (strb_base << off) : '0;
    assign dreq_wdata = (req_on && mem_we_q) ? st_data : '0;

    assign wb_valid    = (state_q == S_DONE);
    assign wb_pc       = pc_q;
    assign wb_rf_we    = rf_we_q && !ale_q;
    assign wb_rf_waddr = waddr_q;
    assign wb_rf_wdata = result_q;
    assign wb_hilo     = hilo_q;
    assign wb_exc_ale  = ale_q;

    // HI/LO write enables are only forwarded once the held result is final.
    assign fwd_rf_we   = wb_rf_we && wb_valid;
    assign fwd_waddr   = waddr_q;
    assign fwd_wdata   = result_q;
    assign fwd_hilo    = {hilo_q[HW-1:HW-2] & {2{wb_valid}}, hilo_q[HW-3:0]};
    assign fwd_ld_busy = (state_q == S_REQ || state_q == S_WAIT) && mem_en_q && !mem_we_q && rf_we_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: a 32-bit and a 64-bit instance share stimulus buses;
// expected WB results are queued at issue and checked by per-instance monitors.
module tb_mem_stage_hs;

    typedef struct {
        logic [31:0]  pc;
        logic         rf_we;
        logic [4:0]   waddr;
        logic [63:0]  wdata;
        logic [129:0] hilo;
        logic         exc;
        logic         chk_data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          flush;
    logic          ex_valid_a, ex_valid_b;
    logic [31:0]   ex_pc;
    logic          ex_mem_en, ex_mem_we, ex_rf_we;
    logic [2:0]    ex_mem_op;
    logic [4:0]    ex_rf_waddr;
    logic [63:0]   ex_result, ex_sdata;
    logic [129:0]  ex_hilo;
    logic          dreq_ready, dresp_valid, wb_ready;
    logic [63:0]   dresp_rdata;

    logic          a_ex_ready, a_dreq_valid, a_dreq_we, a_wb_valid, a_wb_rf_we, a_wb_exc_ale;
    logic          a_fwd_rf_we, a_fwd_ld_busy;
    logic [31:0]   a_dreq_addr, a_dreq_wdata, a_wb_pc, a_wb_rf_wdata, a_fwd_wdata;
    logic [3:0]    a_dreq_wstrb;
    logic [4:0]    a_wb_rf_waddr, a_fwd_waddr;
    logic [65:0]   a_wb_hilo, a_fwd_hilo;

    logic          b_ex_ready, b_dreq_valid, b_dreq_we, b_wb_valid, b_wb_rf_we, b_wb_exc_ale;
    logic          b_fwd_rf_we, b_fwd_ld_busy;
    logic [31:0]   b_dreq_addr, b_wb_pc;
    logic [63:0]   b_dreq_wdata, b_wb_rf_wdata, b_fwd_wdata;
    logic [7:0]    b_dreq_wstrb;
    logic [4:0]    b_wb_rf_waddr, b_fwd_waddr;
    logic [129:0]  b_wb_hilo, b_fwd_hilo;

    int   tests_run = 0;
    int   tests_failed = 0;
    int   a_wb_count = 0;
    int   a_dreq_cycles = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    mem_stage_hs #(.DATA_W(32), .ADDR_W(32), .REG_AW(5)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid_a), .ex_ready(a_ex_ready), .ex_pc(ex_pc),
        .ex_mem_en(ex_mem_en), .ex_mem_we(ex_mem_we), .ex_mem_op(ex_mem_op),
        .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
        .ex_result(ex_result[31:0]), .ex_sdata(ex_sdata[31:0]), .ex_hilo(ex_hilo[65:0]),
        .dreq_valid(a_dreq_valid), .dreq_ready(dreq_ready), .dreq_we(a_dreq_we),
        .dreq_addr(a_dreq_addr), .dreq_wstrb(a_dreq_wstrb), .dreq_wdata(a_dreq_wdata),
        .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata[31:0]),
        .wb_valid(a_wb_valid), .wb_ready(wb_ready), .wb_pc(a_wb_pc),
        .wb_rf_we(a_wb_rf_we), .wb_rf_waddr(a_wb_rf_waddr), .wb_rf_wdata(a_wb_rf_wdata),
        .wb_hilo(a_wb_hilo), .wb_exc_ale(a_wb_exc_ale),
        .fwd_rf_we(a_fwd_rf_we), .fwd_waddr(a_fwd_waddr), .fwd_wdata(a_fwd_wdata),
        .fwd_hilo(a_fwd_hilo), .fwd_ld_busy(a_fwd_ld_busy)
    );

    mem_stage_hs #(.DATA_W(64), .ADDR_W(32), .REG_AW(5)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid_b), .ex_ready(b_ex_ready), .ex_pc(ex_pc),
        .ex_mem_en(ex_mem_en), .ex_mem_we(ex_mem_we), .ex_mem_op(ex_mem_op),
        .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
        .ex_result(ex_result), .ex_sdata(ex_sdata), .ex_hilo(ex_hilo),
        .dreq_valid(b_dreq_valid), .dreq_ready(dreq_ready), .dreq_we(b_dreq_we),
        .dreq_addr(b_dreq_addr), .dreq_wstrb(b_dreq_wstrb), .dreq_wdata(b_dreq_wdata),
        .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
        .wb_valid(b_wb_valid), .wb_ready(wb_ready), .wb_pc(b_wb_pc),
        .wb_rf_we(b_wb_rf_we), .wb_rf_waddr(b_wb_rf_waddr), .wb_rf_wdata(b_wb_rf_wdata),
        .wb_hilo(b_wb_hilo), .wb_exc_ale(b_wb_exc_ale),
        .fwd_rf_we(b_fwd_rf_we), .fwd_waddr(b_fwd_waddr), .fwd_wdata(b_fwd_wdata),
        .fwd_hilo(b_fwd_hilo), .fwd_ld_busy(b_fwd_ld_busy)
    );

    // Scoreboard monitors: every WB handshake pops and checks the oldest expectation.
    always @(negedge clk) begin
        exp_t ea;
        if (rst && a_dreq_valid) a_dreq_cycles++;
        if (rst && a_wb_valid && wb_ready) begin
            a_wb_count++;
            tests_run++;
            if (q_a.size() == 0) begin
                tests_failed++;
                $display("FAIL a_wb_unexpected: got pc=%h, expected no output", a_wb_pc);
            end else begin
                ea = q_a.pop_front();
                if ({a_wb_pc, a_wb_rf_we, a_wb_rf_waddr, a_wb_exc_ale, a_wb_hilo} !==
                        {ea.pc, ea.rf_we, ea.waddr, ea.exc, ea.hilo[65:0]} ||
                        (ea.chk_data && a_wb_rf_wdata !== ea.wdata[31:0])) begin
                    tests_failed++;
                    $display("FAIL a_wb_result: got pc=%h we=%b wa=%0d exc=%b data=%h, expected pc=%h we=%b wa=%0d exc=%b data=%h",
                             a_wb_pc, a_wb_rf_we, a_wb_rf_waddr, a_wb_exc_ale, a_wb_rf_wdata,
                             ea.pc, ea.rf_we, ea.waddr, ea.exc, ea.wdata[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t eb;
        if (rst && b_wb_valid && wb_ready) begin
            tests_run++;
            if (q_b.size() == 0) begin
                tests_failed++;
                $display("FAIL b_wb_unexpected: got pc=%h, expected no output", b_wb_pc);
            end else begin
                eb = q_b.pop_front();
                if ({b_wb_pc, b_wb_rf_we, b_wb_rf_waddr, b_wb_exc_ale, b_wb_hilo} !==
                        {eb.pc, eb.rf_we, eb.waddr, eb.exc, eb.hilo} ||
                        (eb.chk_data && b_wb_rf_wdata !== eb.wdata)) begin
                    tests_failed++;
                    $display("FAIL b_wb_result: got pc=%h we=%b wa=%0d exc=%b data=%h, expected pc=%h we=%b wa=%0d exc=%b data=%h",
                             b_wb_pc, b_wb_rf_we, b_wb_rf_waddr, b_wb_exc_ale, b_wb_rf_wdata,
                             eb.pc, eb.rf_we, eb.waddr, eb.exc, eb.wdata);
                end
            end
        end
    end

    function automatic void push(input bit to_b, input logic [31:0] pc, input logic rfwe,
                                 input logic [4:0] wa, input logic [63:0] wd,
                                 input logic exc, input logic chk);
        exp_t e;
        e.pc = pc; e.rf_we = rfwe; e.waddr = wa; e.wdata = wd;
        e.hilo = ex_hilo; e.exc = exc; e.chk_data = chk;
        if (to_b) q_b.push_back(e);
        else      q_a.push_back(e);
    endfunction

    // Entered and left at posedge+1; holds ex_valid until the chosen instance accepts.
    task automatic send(input bit to_b, input logic [31:0] pc, input logic en, input logic we,
                        input logic [2:0] op, input logic rfwe, input logic [4:0] wa,
                        input logic [63:0] res, input logic [63:0] sd);
        bit ok;
        bit done;
        ex_pc = pc; ex_mem_en = en; ex_mem_we = we; ex_mem_op = op;
        ex_rf_we = rfwe; ex_rf_waddr = wa; ex_result = res; ex_sdata = sd;
        if (to_b) ex_valid_b = 1'b1;
        else      ex_valid_a = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            ok = to_b ? b_ex_ready : a_ex_ready;
            @(posedge clk); #1;
            if (ok) done = 1'b1;
        end
        ex_valid_a = 1'b0;
        ex_valid_b = 1'b0;
        if (!done) begin
            tests_run++; tests_failed++;
            $display("FAIL send_timeout: ex_ready stayed 0, expected acceptance of pc=%h", pc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #2;
        tests_run++;
        if ({a_ex_ready, b_ex_ready} !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_ex_ready: got %b, expected 11", {a_ex_ready, b_ex_ready});
        end
        tests_run++;
        if ({a_dreq_valid, a_wb_valid, a_fwd_rf_we, a_fwd_ld_busy, a_wb_exc_ale, a_wb_rf_we,
             b_dreq_valid, b_wb_valid, b_fwd_rf_we, b_fwd_ld_busy, b_wb_exc_ale, b_wb_rf_we} !== 12'h0) begin
            tests_failed++;
            $display("FAIL reset_flags: got a_req=%b a_wb=%b b_req=%b b_wb=%b, expected all 0",
                     a_dreq_valid, a_wb_valid, b_dreq_valid, b_wb_valid);
        end
        tests_run++;
        if ({a_wb_rf_wdata, a_dreq_addr, a_wb_pc, b_wb_rf_wdata, b_dreq_wstrb} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got a_data=%h a_addr=%h b_data=%h, expected 0",
                     a_wb_rf_wdata, a_dreq_addr, b_wb_rf_wdata);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_alu_b2b();
        time t0;
        int  cnt0, dq0;
        wb_ready = 1'b1;
        ex_hilo  = 130'({2'b11, 32'h0000_CAFE, 32'h0000_BEEF});
        t0   = $time;
        cnt0 = a_wb_count;
        dq0  = a_dreq_cycles;
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 32'h100 + 32'(4 * i), 1'b1, 5'(i + 1), 64'hA000 + 64'(i), 1'b0, 1'b1);
            send(1'b0, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 3'd0, 1'b1, 5'(i + 1), 64'hA000 + 64'(i), 64'h0);
        end
        tests_run++;
        if ($time - t0 != 40) begin
            tests_failed++;
            $display("FAIL alu_throughput: got %0t time units for 4 issues, expected 40", $time - t0);
        end
        @(negedge clk);
        tests_run++;
        if ({a_fwd_rf_we, a_fwd_waddr, a_fwd_wdata, a_fwd_hilo} !== {1'b1, 5'd4, 32'hA003, ex_hilo[65:0]}) begin
            tests_failed++;
            $display("FAIL alu_forward: got we=%b wa=%0d data=%h hilo=%h, expected 1 4 0000a003 %h",
                     a_fwd_rf_we, a_fwd_waddr, a_fwd_wdata, a_fwd_hilo, ex_hilo[65:0]);
        end
        @(posedge clk); #1;
        tests_run++;
        if (a_wb_count - cnt0 != 4 || a_dreq_cycles != dq0) begin
            tests_failed++;
            $display("FAIL alu_count: got %0d outputs %0d dreq cycles, expected 4 and 0",
                     a_wb_count - cnt0, a_dreq_cycles - dq0);
        end
        ex_hilo = '0;
    endtask

    task automatic test_load_lb();
        push(1'b0, 32'h200, 1'b1, 5'd5, 64'hFFFF_FF80, 1'b0, 1'b1);
        send(1'b0, 32'h200, 1'b1, 1'b0, 3'd0, 1'b1, 5'd5, 64'h1003, 64'h0);
        dreq_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({a_dreq_valid, a_dreq_we, a_dreq_addr, a_fwd_ld_busy} !== {1'b1, 1'b0, 32'h1000, 1'b1}) begin
            tests_failed++;
            $display("FAIL lb_request: got v=%b we=%b addr=%h busy=%b, expected 1 0 00001000 1",
                     a_dreq_valid, a_dreq_we, a_dreq_addr, a_fwd_ld_busy);
        end
        @(posedge clk); #1;
        dreq_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if ({a_fwd_ld_busy, a_dreq_valid, a_wb_valid} !== 3'b100) begin
                tests_failed++;
                $display("FAIL lb_wait: got busy=%b req=%b wb=%b, expected 1 0 0",
                         a_fwd_ld_busy, a_dreq_valid, a_wb_valid);
            end
            @(posedge clk); #1;
        end
        dresp_valid = 1'b1;
        dresp_rdata = 64'h80FF_FFFF;
        @(posedge clk); #1;
        dresp_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({a_wb_valid, a_fwd_rf_we, a_fwd_waddr, a_fwd_wdata, a_fwd_ld_busy} !==
                {1'b1, 1'b1, 5'd5, 32'hFFFF_FF80, 1'b0}) begin
            tests_failed++;
            $display("FAIL lb_result: got wb=%b fwd=%b wa=%0d data=%h busy=%b, expected 1 1 5 ffffff80 0",
                     a_wb_valid, a_fwd_rf_we, a_fwd_waddr, a_fwd_wdata, a_fwd_ld_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_sh();
        push(1'b0, 32'h300, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
        send(1'b0, 32'h300, 1'b1, 1'b1, 3'd2, 1'b0, 5'd0, 64'h2002, 64'hDEAD_1234);
        dreq_ready  = 1'b1;
        dresp_valid = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({a_dreq_valid, a_dreq_we, a_dreq_addr, a_dreq_wstrb, a_dreq_wdata} !==
                {1'b1, 1'b1, 32'h2000, 4'b1100, 32'h1234_1234}) begin
            tests_failed++;
            $display("FAIL sh_request: got v=%b we=%b addr=%h strb=%b wdata=%h, expected 1 1 00002000 1100 12341234",
                     a_dreq_valid, a_dreq_we, a_dreq_addr, a_dreq_wstrb, a_dreq_wdata);
        end
        @(posedge clk); #1;
        dreq_ready  = 1'b0;
        dresp_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({a_wb_valid, a_wb_rf_we, a_fwd_rf_we, a_dreq_valid} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL sh_ack: got wb=%b rf_we=%b fwd=%b req=%b, expected 1 0 0 0",
                     a_wb_valid, a_wb_rf_we, a_fwd_rf_we, a_dreq_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_misaligned();
        logic [2:0]  ops [2]   = '{3'd4, 3'd5};
        logic [63:0] addrs [2] = '{64'h3001, 64'h3004};
        for (int i = 0; i < 2; i++) begin
            push(1'b0, 32'h400 + 32'(4 * i), 1'b0, 5'd3, 64'h0, 1'b1, 1'b0);
            send(1'b0, 32'h400 + 32'(4 * i), 1'b1, 1'b0, ops[i], 1'b1, 5'd3, addrs[i], 64'h0);
            @(negedge clk);
            tests_run++;
            if ({a_dreq_valid, a_wb_valid, a_wb_exc_ale, a_wb_rf_we, a_fwd_rf_we} !== 5'b01100) begin
                tests_failed++;
                $display("FAIL misaligned_%0d: got req=%b wb=%b ale=%b rf_we=%b fwd=%b, expected 0 1 1 0 0",
                         i, a_dreq_valid, a_wb_valid, a_wb_exc_ale, a_wb_rf_we, a_fwd_rf_we);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        send(1'b0, 32'h500, 1'b1, 1'b0, 3'd4, 1'b1, 5'd4, 64'h4000, 64'h0);
        dreq_ready = 1'b1;
        @(posedge clk); #1;
        dreq_ready = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if ({a_ex_ready, a_wb_valid} !== 2'b00) begin
                tests_failed++;
                $display("FAIL flush_drain: got ex_ready=%b wb=%b, expected 0 0", a_ex_ready, a_wb_valid);
            end
            @(posedge clk); #1;
        end
        dresp_valid = 1'b1;
        dresp_rdata = 64'h55;
        @(posedge clk); #1;
        dresp_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({a_ex_ready, a_wb_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL flush_release: got ex_ready=%b wb=%b, expected 1 0", a_ex_ready, a_wb_valid);
        end
        @(posedge clk); #1;

        send(1'b0, 32'h504, 1'b1, 1'b0, 3'd4, 1'b1, 5'd4, 64'h4004, 64'h0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({a_dreq_valid, a_ex_ready, a_wb_valid} !== 3'b010) begin
            tests_failed++;
            $display("FAIL flush_withdraw: got req=%b ex_ready=%b wb=%b, expected 0 1 0",
                     a_dreq_valid, a_ex_ready, a_wb_valid);
        end
        @(posedge clk); #1;

        send(1'b0, 32'h508, 1'b1, 1'b0, 3'd4, 1'b1, 5'd4, 64'h4008, 64'h0);
        dreq_ready = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        dreq_ready = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({a_dreq_valid, a_ex_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL flush_accept_drain: got req=%b ex_ready=%b, expected 0 0", a_dreq_valid, a_ex_ready);
        end
        @(posedge clk); #1;
        dresp_valid = 1'b1;
        @(posedge clk); #1;
        dresp_valid = 1'b0;

        ex_pc = 32'h50C; ex_mem_en = 1'b0; ex_rf_we = 1'b1; ex_result = 64'h77;
        ex_valid_a = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        ex_valid_a = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({a_wb_valid, a_ex_ready, a_dreq_valid} !== 3'b010) begin
            tests_failed++;
            $display("FAIL flush_priority: got wb=%b ex_ready=%b req=%b, expected 0 1 0",
                     a_wb_valid, a_ex_ready, a_dreq_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wide_64();
        wb_ready = 1'b0;
        push(1'b1, 32'h600, 1'b1, 5'd7, 64'h0000_0000_8000_0001, 1'b0, 1'b1);
        send(1'b1, 32'h600, 1'b1, 1'b0, 3'd5, 1'b1, 5'd7, 64'h5004, 64'h0);
        dreq_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({b_dreq_valid, b_dreq_we, b_dreq_addr, b_fwd_ld_busy} !== {1'b1, 1'b0, 32'h5000, 1'b1}) begin
            tests_failed++;
            $display("FAIL lwu64_request: got v=%b we=%b addr=%h busy=%b, expected 1 0 00005000 1",
                     b_dreq_valid, b_dreq_we, b_dreq_addr, b_fwd_ld_busy);
        end
        @(posedge clk); #1;
        dreq_ready  = 1'b0;
        dresp_valid = 1'b1;
        dresp_rdata = 64'h8000_0001_FFFF_FFFF;
        @(posedge clk); #1;
        dresp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ({b_wb_valid, b_ex_ready, b_wb_rf_wdata, b_fwd_rf_we, b_fwd_waddr, b_fwd_wdata, b_fwd_hilo} !==
                    {1'b1, 1'b0, 64'h0000_0000_8000_0001, 1'b1, 5'd7, 64'h0000_0000_8000_0001, 130'h0}) begin
                tests_failed++;
                $display("FAIL lwu64_hold_%0d: got wb=%b ex_ready=%b data=%h fwd=%b, expected 1 0 0000000080000001 1",
                         i, b_wb_valid, b_ex_ready, b_wb_rf_wdata, b_fwd_rf_we);
            end
            @(posedge clk); #1;
        end
        wb_ready = 1'b1;
        @(posedge clk); #1;

        push(1'b1, 32'h604, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
        send(1'b1, 32'h604, 1'b1, 1'b1, 3'd0, 1'b0, 5'd0, 64'h5105, 64'hAB);
        dreq_ready  = 1'b1;
        dresp_valid = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({b_dreq_we, b_dreq_addr, b_dreq_wstrb, b_dreq_wdata} !==
                {1'b1, 32'h5100, 8'h20, 64'hABAB_ABAB_ABAB_ABAB}) begin
            tests_failed++;
            $display("FAIL sb64_request: got we=%b addr=%h strb=%h wdata=%h, expected 1 00005100 20 abababababababab",
                     b_dreq_we, b_dreq_addr, b_dreq_wstrb, b_dreq_wdata);
        end
        @(posedge clk); #1;
        dreq_ready  = 1'b0;
        dresp_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        send(1'b0, 32'h700, 1'b1, 1'b0, 3'd4, 1'b1, 5'd9, 64'h6000, 64'h0);
        dreq_ready = 1'b1;
        @(posedge clk); #1;
        dreq_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({a_ex_ready, a_dreq_valid, a_fwd_ld_busy, a_wb_valid} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL async_reset: got ex_ready=%b req=%b busy=%b wb=%b, expected 1 0 0 0",
                     a_ex_ready, a_dreq_valid, a_fwd_ld_busy, a_wb_valid);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({a_ex_ready, a_wb_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL async_reset_release: got ex_ready=%b wb=%b, expected 1 0", a_ex_ready, a_wb_valid);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        flush = 1'b0; ex_valid_a = 1'b0; ex_valid_b = 1'b0;
        ex_pc = '0; ex_mem_en = 1'b0; ex_mem_we = 1'b0; ex_mem_op = '0;
        ex_rf_we = 1'b0; ex_rf_waddr = '0; ex_result = '0; ex_sdata = '0; ex_hilo = '0;
        dreq_ready = 1'b0; dresp_valid = 1'b0; dresp_rdata = '0; wb_ready = 1'b1;

        test_reset();
        test_alu_b2b();
        test_load_lb();
        test_store_sh();
        test_misaligned();
        test_flush();
        test_wide_64();
        test_async_reset();

        repeat (2) @(posedge clk);
        tests_run++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending results, expected 0/0", q_a.size(), q_b.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
